// File: rtl/psum_drain_pkg.sv
// Shared types and sizing for the OFIFO psum drain.
// Widths default to a 16-bit, 8-column corelet with 4 guard bits.
package psum_drain_pkg;

    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int GUARD   = 4;
    localparam int AW      = PSUM_BW + GUARD;
    localparam int PASS_W  = 4;
    localparam int IDX_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/psum_drain_if.sv
// OFIFO read side plus the downstream valid/ready vector port.
// The drain block is the master; the OFIFO/downstream side is the slave.
interface psum_drain_if #(
    parameter int PSUM_BW = 16,
    parameter int COL     = 8,
    parameter int AW      = 20
);
    logic                   ofifo_valid;
    logic [PSUM_BW*COL-1:0] ofifo_rdata;
    logic                   ofifo_rd;
    logic                   out_valid;
    logic                   out_ready;
    logic [AW*COL-1:0]      out_data;
    logic [7:0]             out_idx;

    modport master (
        input  ofifo_valid, ofifo_rdata, out_ready,
        output ofifo_rd, out_valid, out_data, out_idx
    );

    modport slave (
        output ofifo_valid, ofifo_rdata, out_ready,
        input  ofifo_rd, out_valid, out_data, out_idx
    );
endinterface

// File: rtl/psum_acc_lane.sv
// One column accumulator: load (first pass) or add a sign-extended psum.
// Wraps modulo 2^AW; guard bits make wrap impossible for up to 16 passes.
module psum_acc_lane #(
    parameter int PSUM_BW = 16,
    parameter int AW      = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               add,
    input  logic [PSUM_BW-1:0] in,
    output logic [AW-1:0]      acc
);
    logic [AW-1:0] acc_q;
    logic [AW-1:0] ext;

    assign ext = {{(AW-PSUM_BW){in[PSUM_BW-1]}}, in};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     acc_q <= '0;
        else if (load) acc_q <= ext;
        else if (add)  acc_q <= acc_q + ext;
    end

    assign acc = acc_q;
endmodule

// File: rtl/psum_drain.sv
// Pops OFIFO psum words, accumulates num_pass+1 of them per column and
// hands each finished vector downstream; num_out+1 vectors per job.
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int col     = COL,
    parameter int guard   = GUARD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PASS_W-1:0] num_pass,
    input  logic [IDX_W-1:0]  num_out,
    psum_drain_if.master      bus,
    output logic              busy,
    output logic              done
);
    localparam int aw = psum_bw + guard;

    state_t             state_q, state_d;
    logic [PASS_W-1:0]  pass_q, pass_d, npass_q, npass_d;
    logic [IDX_W-1:0]   idx_q, idx_d, nout_q, nout_d;
    logic               pop, load, add;
    logic [col-1:0][aw-1:0] acc;

    // Pass 0 overwrites the lane so no separate clear cycle is needed.
    assign pop  = bus.ofifo_rd;
    assign load = pop && (pass_q == '0);
    assign add  = pop && (pass_q != '0);

    for (genvar c = 0; c < col; c++) begin : g_lane
        psum_acc_lane #(.PSUM_BW(psum_bw), .AW(aw)) u_lane (
            .clk   (clk),
            .reset (reset),
            .load  (load),
            .add   (add),
            .in    (bus.ofifo_rdata[psum_bw*c +: psum_bw]),
            .acc   (acc[c])
        );
    end

    assign bus.out_data = acc;
    assign bus.out_idx  = idx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pass_q  <= '0;
            idx_q   <= '0;
            npass_q <= '0;
            nout_q  <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            idx_q   <= idx_d;
            npass_q <= npass_d;
            nout_q  <= nout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        idx_d   = idx_q;
        npass_d = npass_q;
        nout_d  = nout_q;
        case (state_q)
            IDLE: if (start) begin
                npass_d = num_pass;
                nout_d  = num_out;
                pass_d  = '0;
                idx_d   = '0;
                state_d = ACC;
            end
            ACC: if (pop) begin
                if (pass_q == npass_q) begin
                    pass_d  = '0;
                    state_d = EMIT;
                end else begin
                    pass_d = pass_q + 1'b1;
                end
            end
            EMIT: if (bus.out_ready) begin
                if (idx_q == nout_q) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ACC;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ofifo_rd  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = (state_q != IDLE);
        done          = 1'b0;
        case (state_q)
            ACC:     bus.ofifo_rd  = bus.ofifo_valid;
            EMIT:    bus.out_valid = 1'b1;
            DONE:    done          = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_psum_drain.sv
// Scenario bench for psum_drain: expected vectors are queued as words are
// driven and popped when the DUT presents a vector.
module tb_psum_drain;
    import psum_drain_pkg::*;

    localparam int PBW = 16;
    localparam int NC  = 8;
    localparam int W   = 20;

    typedef int colv_t [NC];
    typedef struct {
        logic [7:0]      idx;
        logic [NC*W-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] num_pass;
    logic [7:0] num_out;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    psum_drain_if #(.PSUM_BW(PBW), .COL(NC), .AW(W)) bus ();

    psum_drain #(.psum_bw(PBW), .col(NC), .guard(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .num_pass (num_pass),
        .num_out  (num_out),
        .bus      (bus),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic colv_t all(input int x);
        colv_t v;
        for (int c = 0; c < NC; c++) v[c] = x;
        return v;
    endfunction

    function automatic logic [NC*PBW-1:0] wrd(input colv_t v);
        logic [NC*PBW-1:0] w;
        for (int c = 0; c < NC; c++) w[c*PBW +: PBW] = PBW'(v[c]);
        return w;
    endfunction

    function automatic logic [NC*W-1:0] vec(input colv_t v);
        logic [NC*W-1:0] d;
        for (int c = 0; c < NC; c++) d[c*W +: W] = W'(v[c]);
        return d;
    endfunction

    // All stimulus tasks start and end at posedge+1.
    task automatic do_start(input logic [3:0] np, input logic [7:0] no);
        num_pass = np;
        num_out  = no;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input logic [NC*PBW-1:0] w);
        bit got;
        got = 1'b0;
        bus.ofifo_valid = 1'b1;
        bus.ofifo_rdata = w;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = bus.ofifo_rd;
            @(posedge clk); #1;
        end
        bus.ofifo_valid = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("FAIL feed_timeout: ofifo_rd=0 required 1");
        end
    endtask

    // Leaves the bench at a negedge with out_valid=1.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) return;
        end
        total++; bad++;
        $display("FAIL out_valid_timeout: out_valid=0 required 1");
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 50; k++) begin
            if (!busy) return;
            @(posedge clk); #1;
        end
        total++; bad++;
        $display("FAIL idle_timeout: busy=1 required 0");
    endtask

    task automatic pop_exp();
        if (sb.size() > 0) e = sb.pop_front();
        else begin
            e.idx = 8'hxx; e.data = 'x;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; num_pass = '0; num_out = '0;
        bus.ofifo_valid = 1'b1; bus.ofifo_rdata = '1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        total++; if (bus.ofifo_rd !== 1'b0) begin bad++; $display("FAIL rst_rd: got %b want 0", bus.ofifo_rd); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_data !== '0) begin bad++; $display("FAIL rst_data: got %h want 0", bus.out_data); end
        total++; if (bus.out_idx !== 8'd0) begin bad++; $display("FAIL rst_idx: got %0d want 0", bus.out_idx); end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if (bus.ofifo_rd !== 1'b0) begin bad++; $display("FAIL idle_rd: got %b want 0", bus.ofifo_rd); end
            @(posedge clk); #1;
        end
        bus.ofifo_valid = 1'b0;
    endtask

    task automatic test_single();
        colv_t v;
        int lat;
        v = all(0); v[0] = 5; v[7] = -3;
        do_start(4'd0, 8'd0);
        sb.push_back('{idx: 8'd0, data: vec(v)});
        feed(wrd(v));
        wait_valid(lat);
        pop_exp();
        total++; if (lat !== 1) begin bad++; $display("FAIL single_latency: got %0d want 1", lat); end
        total++; if (bus.out_data !== e.data) begin bad++; $display("FAIL single_data: got %h want %h", bus.out_data, e.data); end
        total++; if (bus.out_data[19:0] !== 20'h00005) begin bad++; $display("FAIL single_col0: got %h want 00005", bus.out_data[19:0]); end
        total++; if (bus.out_data[159:140] !== 20'hFFFFD) begin bad++; $display("FAIL single_col7: got %h want FFFFD", bus.out_data[159:140]); end
        total++; if (bus.out_idx !== e.idx) begin bad++; $display("FAIL single_idx: got %0d want %0d", bus.out_idx, e.idx); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (done !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL single_done: done=%b busy=%b want 1 1", done, busy); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_idle: done=%b busy=%b want 0 0", done, busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_multipass();
        int cnt;
        int lat;
        do_start(4'd3, 8'd0);
        sb.push_back('{idx: 8'd0, data: vec(all(4000))});
        bus.out_ready   = 1'b0;
        bus.ofifo_valid = 1'b1;
        bus.ofifo_rdata = wrd(all(1000));
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.ofifo_rd) cnt++;
            @(posedge clk); #1;
        end
        bus.ofifo_valid = 1'b0;
        total++; if (cnt !== 4) begin bad++; $display("FAIL mp_pops: got %0d want 4", cnt); end
        wait_valid(lat);
        pop_exp();
        total++; if (bus.out_data !== e.data) begin bad++; $display("FAIL mp_data: got %h want %h", bus.out_data, e.data); end
        total++; if (bus.out_idx !== e.idx) begin bad++; $display("FAIL mp_idx: got %0d want %0d", bus.out_idx, e.idx); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        wait_idle();
    endtask

    task automatic test_extremes();
        int lat;
        do_start(4'd15, 8'd1);
        sb.push_back('{idx: 8'd0, data: vec(all(524272))});
        sb.push_back('{idx: 8'd1, data: vec(all(-524288))});
        for (int i = 0; i < 16; i++) feed(wrd(all(32767)));
        wait_valid(lat);
        pop_exp();
        total++; if (bus.out_data !== e.data) begin bad++; $display("FAIL max_data: got %h want %h", bus.out_data, e.data); end
        total++; if (bus.out_idx !== e.idx) begin bad++; $display("FAIL max_idx: got %0d want %0d", bus.out_idx, e.idx); end
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) feed(wrd(all(-32768)));
        wait_valid(lat);
        pop_exp();
        total++; if (bus.out_data !== e.data) begin bad++; $display("FAIL min_data: got %h want %h", bus.out_data, e.data); end
        total++; if (bus.out_data[19:0] !== 20'h80000) begin bad++; $display("FAIL min_col0: got %h want 80000", bus.out_data[19:0]); end
        total++; if (bus.out_idx !== e.idx) begin bad++; $display("FAIL min_idx: got %0d want %0d", bus.out_idx, e.idx); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ext_done: got %b want 1", done); end
        @(posedge clk); #1;
        wait_idle();
    endtask

    task automatic test_backpressure();
        colv_t v0, v1;
        int lat;
        v0 = all(-7); v0[3] = 100;
        v1 = all(42); v1[6] = -1;
        do_start(4'd0, 8'd1);
        sb.push_back('{idx: 8'd0, data: vec(v0)});
        sb.push_back('{idx: 8'd1, data: vec(v1)});
        bus.out_ready = 1'b0;
        feed(wrd(v0));
        bus.ofifo_valid = 1'b1;
        bus.ofifo_rdata = wrd(v1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", bus.out_valid); end
            total++; if (bus.out_data !== sb[0].data) begin bad++; $display("FAIL bp_data: got %h want %h", bus.out_data, sb[0].data); end
            total++; if (bus.out_idx !== 8'd0) begin bad++; $display("FAIL bp_idx: got %0d want 0", bus.out_idx); end
            total++; if (bus.ofifo_rd !== 1'b0) begin bad++; $display("FAIL bp_rd: got %b want 0", bus.ofifo_rd); end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        pop_exp();
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== e.data) begin bad++; $display("FAIL bp_hs_data: valid=%b got %h want %h", bus.out_valid, bus.out_data, e.data); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (bus.ofifo_rd !== 1'b1) begin bad++; $display("FAIL bp_resume: got %b want 1", bus.ofifo_rd); end
        @(posedge clk); #1;
        bus.ofifo_valid = 1'b0;
        wait_valid(lat);
        pop_exp();
        total++; if (bus.out_data !== e.data) begin bad++; $display("FAIL bp_v1_data: got %h want %h", bus.out_data, e.data); end
        total++; if (bus.out_idx !== e.idx) begin bad++; $display("FAIL bp_v1_idx: got %0d want %0d", bus.out_idx, e.idx); end
        @(posedge clk); #1;
        wait_idle();
    endtask

    task automatic test_gaps();
        colv_t w [3];
        colv_t s;
        bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int j;
        int lat;
        w[0] = all(11); w[1] = all(-300);
        for (int c = 0; c < NC; c++) w[2][c] = c * 1000 - 4000;
        for (int c = 0; c < NC; c++) s[c] = w[0][c] + w[1][c] + w[2][c];
        do_start(4'd2, 8'd0);
        sb.push_back('{idx: 8'd0, data: vec(s)});
        j = 0;
        for (int i = 0; i < 6; i++) begin
            bus.ofifo_valid = pat[i];
            bus.ofifo_rdata = pat[i] ? wrd(w[j]) : wrd(all(12345));
            @(negedge clk);
            total++; if (bus.ofifo_rd !== pat[i]) begin bad++; $display("FAIL gap_rd%0d: got %b want %b", i, bus.ofifo_rd, pat[i]); end
            @(posedge clk); #1;
            if (pat[i]) j++;
        end
        bus.ofifo_valid = 1'b0;
        wait_valid(lat);
        pop_exp();
        total++; if (lat !== 1) begin bad++; $display("FAIL gap_latency: got %0d want 1", lat); end
        total++; if (bus.out_data !== e.data) begin bad++; $display("FAIL gap_data: got %h want %h", bus.out_data, e.data); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL gap_done: got %b want 1", done); end
        @(posedge clk); #1;
        wait_idle();
    endtask

    task automatic test_start_ignored();
        colv_t a, b, s;
        int lat;
        a = all(250); a[1] = -9000;
        b = all(-17); b[5] = 3000;
        for (int c = 0; c < NC; c++) s[c] = a[c] + b[c];
        do_start(4'd1, 8'd0);
        sb.push_back('{idx: 8'd0, data: vec(s)});
        feed(wrd(a));
        do_start(4'd0, 8'd3);
        feed(wrd(b));
        wait_valid(lat);
        pop_exp();
        total++; if (lat !== 1) begin bad++; $display("FAIL ign_latency: got %0d want 1", lat); end
        total++; if (bus.out_data !== e.data) begin bad++; $display("FAIL ign_data: got %h want %h", bus.out_data, e.data); end
        total++; if (bus.out_idx !== e.idx) begin bad++; $display("FAIL ign_idx: got %0d want %0d", bus.out_idx, e.idx); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ign_done: got %b want 1", done); end
        @(posedge clk); #1;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        colv_t p, q, s;
        int lat;
        p = all(77); p[2] = -1234;
        q = all(5);  q[4] = 999;
        for (int c = 0; c < NC; c++) s[c] = p[c] + q[c];
        do_start(4'd3, 8'd0);
        feed(wrd(all(20000)));
        feed(wrd(all(20000)));
        bus.ofifo_valid = 1'b1;
        bus.ofifo_rdata = wrd(all(20000));
        reset = 1'b1;
        #1;
        total++; if (bus.ofifo_rd !== 1'b0) begin bad++; $display("FAIL rm_rd: got %b want 0", bus.ofifo_rd); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rm_busy: busy=%b done=%b want 0 0", busy, done); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_data !== '0 || bus.out_idx !== 8'd0) begin bad++; $display("FAIL rm_data: got %h idx %0d want 0", bus.out_data, bus.out_idx); end
        @(posedge clk); #1;
        reset = 1'b0;
        bus.ofifo_valid = 1'b0;
        @(posedge clk); #1;
        do_start(4'd1, 8'd0);
        sb.push_back('{idx: 8'd0, data: vec(s)});
        feed(wrd(p));
        feed(wrd(q));
        wait_valid(lat);
        pop_exp();
        total++; if (bus.out_data !== e.data) begin bad++; $display("FAIL rm_new_data: got %h want %h", bus.out_data, e.data); end
        @(posedge clk); #1;
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_multipass();
        test_extremes();
        test_backpressure();
        test_gaps();
        test_start_ignored();
        test_reset_mid();
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
